// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the M-stage memory bus adapter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } mem_state_e;

    localparam int unsigned TIMEOUT_DEFAULT    = 15;
    localparam logic [31:0] FAULT_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return byte_addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_bus_if_if.sv
// Data-memory bus signal bundle; the adapter is the master, memory the slave.
interface mem_bus_if_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata, bus_err
    );
endinterface

// File: rtl/mem_timeout.sv
// ACCESS-phase cycle counter: cleared outside ACCESS, flags expiry at TIMEOUT.
module mem_timeout #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired_o = en_i && (count_q == CW'(TIMEOUT));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_bus_if.sv
// Memory-stage bus adapter: turns M-stage load/store requests into single
// request/ack bus cycles, stalling the pipeline until the access resolves.
module mem_bus_if
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
    parameter logic [31:0] FAULT_DATA = FAULT_DATA_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [31:0]   ALUOutM,
    input  logic [31:0]   WriteDataM,
    output logic [31:0]   ReadDataM,
    output logic          StallM,
    output logic          MemFault,
    mem_bus_if_if.master  bus
);

    mem_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        req_present;
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_expired;

    assign req_present = MemReadM | MemWriteM;

    mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        StallM  = 1'b0;
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_present) begin
                    StallM = 1'b1;
                    if (is_misaligned(ALUOutM)) begin
                        rdata_d = '0;
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // A simultaneous read+write is issued as a write.
                        we_d    = MemWriteM;
                        addr_d  = word_addr(ALUOutM);
                        wdata_d = WriteDataM;
                        state_d = S_ACCESS;
                    end
                end
            end

            S_ACCESS: begin
                StallM  = 1'b1;
                cnt_clr = 1'b0;
                cnt_en  = 1'b1;
                // Ack takes priority over an expiry in the same cycle.
                if (bus.bus_ack) begin
                    rdata_d = we_q ? '0 : bus.bus_rdata;
                    if (bus.bus_err) begin
                        fault_d = 1'b1;
                    end
                    state_d = S_DONE;
                end else if (cnt_expired) begin
                    rdata_d = FAULT_DATA;
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign bus.bus_req   = (state_q == S_ACCESS);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign ReadDataM     = rdata_q;
    assign MemFault      = fault_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Self-checking bench for mem_bus_if: vector table with a result scoreboard,
// plus hand-written reset/hold sequences.
module tb_mem_bus_if;
    import mem_bus_pkg::*;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MemFault;

    mem_bus_if_if bus ();

    mem_bus_if #(
        .TIMEOUT    (TO),
        .FAULT_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MemFault   (MemFault),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;     // ACCESS cycle (1-based) carrying ack; 0 = never
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_stall;
        int          exp_req;
        logic        exp_we;
        logic [31:0] exp_baddr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        MemReadM = 1'b0;
        MemWriteM = 1'b0;
        bus.bus_ack = 1'b0;
        bus.bus_err = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   stall_n;
        int   req_n;
        int   bad;
        bit   done;
        sb_t  e;
        if (v.rst_before) do_reset();
        @(negedge clk);
        MemReadM   = v.rd;
        MemWriteM  = v.wr;
        ALUOutM    = v.addr;
        WriteDataM = v.wdata;
        bus.bus_ack = 1'b0;
        bus.bus_err = 1'b0;
        e.rdata = v.exp_rdata;
        e.fault = v.exp_fault;
        sb_q.push_back(e);
        #1;
        stall_n = StallM ? 1 : 0;
        req_n = 0;
        bad = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            bus.bus_ack   = 1'b0;
            bus.bus_err   = 1'b0;
            bus.bus_rdata = $urandom;
            if (!StallM) begin
                done = 1;
                MemReadM  = 1'b0;
                MemWriteM = 1'b0;
                chk($sformatf("v%0d_done_req", idx), {31'b0, bus.bus_req}, 32'd0);
                if (sb_q.size() == 0) begin
                    chk($sformatf("v%0d_sb_nonempty", idx), 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("v%0d_rdata", idx), ReadDataM, e.rdata);
                    chk($sformatf("v%0d_fault", idx), {31'b0, MemFault}, {31'b0, e.fault});
                end
                chk($sformatf("v%0d_stall_cycles", idx), stall_n, v.exp_stall);
                chk($sformatf("v%0d_req_cycles", idx), req_n, v.exp_req);
                chk($sformatf("v%0d_bus_fields", idx), bad, 0);
            end else begin
                stall_n++;
                if (bus.bus_req) begin
                    req_n++;
                    if (bus.bus_we !== v.exp_we || bus.bus_addr !== v.exp_baddr ||
                        bus.bus_wdata !== v.wdata)
                        bad++;
                    if (req_n == v.ack_at) begin
                        bus.bus_ack   = 1'b1;
                        bus.bus_rdata = v.rdata;
                        bus.bus_err   = v.err;
                    end
                end
            end
        end
        if (!done) begin
            chk($sformatf("v%0d_done_reached", idx), 32'd0, 32'd1);
            MemReadM  = 1'b0;
            MemWriteM = 1'b0;
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.bus_ack   = 1'b0;
        bus.bus_err   = 1'b0;
        bus.bus_rdata = '0;

        //          rst rd wr addr           wdata          ack rdata          err exp_rdata      f  stl req we baddr
        vecs[0]  = '{0, 1, 0, 32'h0000_0100, 32'h0000_0000, 1,  32'h1234_5678, 0,  32'h1234_5678, 0, 2,  1,  0, 32'h0000_0040};
        vecs[1]  = '{0, 0, 1, 32'h0000_0200, 32'hCAFE_F00D, 4,  32'h0000_0000, 0,  32'h0000_0000, 0, 5,  4,  1, 32'h0000_0080};
        vecs[2]  = '{0, 1, 0, 32'h0000_0010, 32'h0000_0000, 2,  32'hA5A5_0001, 0,  32'hA5A5_0001, 0, 3,  2,  0, 32'h0000_0004};
        vecs[3]  = '{0, 1, 0, 32'h0000_0014, 32'h0000_0000, 1,  32'h0000_BEEF, 0,  32'h0000_BEEF, 0, 2,  1,  0, 32'h0000_0005};
        vecs[4]  = '{0, 1, 1, 32'h0000_0020, 32'h1111_2222, 1,  32'h7777_7777, 0,  32'h0000_0000, 0, 2,  1,  1, 32'h0000_0008};
        vecs[5]  = '{0, 1, 0, 32'h0000_0040, 32'h0000_0000, 16, 32'h0BAD_F00D, 0,  32'h0BAD_F00D, 0, 17, 16, 0, 32'h0000_0010};
        vecs[6]  = '{1, 1, 0, 32'h0000_0103, 32'h0000_0000, 1,  32'h1357_9BDF, 0,  32'h0000_0000, 1, 1,  0,  0, 32'h0000_0000};
        vecs[7]  = '{1, 1, 0, 32'h0000_0300, 32'h0000_0000, 0,  32'h0000_0000, 0,  32'hDEAD_BEEF, 1, 17, 16, 0, 32'h0000_00C0};
        vecs[8]  = '{1, 1, 0, 32'h0000_0104, 32'h0000_0000, 2,  32'h55AA_55AA, 1,  32'h55AA_55AA, 1, 3,  2,  0, 32'h0000_0041};
        vecs[9]  = '{0, 0, 1, 32'h0000_0202, 32'h0000_0001, 1,  32'h0000_0000, 0,  32'h0000_0000, 1, 1,  0,  0, 32'h0000_0000};
        vecs[10] = '{0, 1, 0, 32'h0000_0304, 32'h0000_0000, 1,  32'h600D_CAFE, 0,  32'h600D_CAFE, 1, 2,  1,  0, 32'h0000_00C1};

        // Asynchronous reset values before any clock edge.
        #2;
        chk("rst_bus_req",   {31'b0, bus.bus_req}, 32'd0);
        chk("rst_bus_we",    {31'b0, bus.bus_we},  32'd0);
        chk("rst_bus_addr",  bus.bus_addr,  32'd0);
        chk("rst_bus_wdata", bus.bus_wdata, 32'd0);
        chk("rst_rdata",     ReadDataM,     32'd0);
        chk("rst_fault",     {31'b0, MemFault}, 32'd0);
        chk("rst_stall",     {31'b0, StallM},   32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // ReadDataM holds in IDLE, then a reset lands mid-ACCESS.
        @(negedge clk);
        chk("hold_rdata", ReadDataM, 32'h600D_CAFE);
        MemReadM = 1'b1;
        ALUOutM  = 32'h0000_0400;
        repeat (2) @(negedge clk);
        chk("mid_req_before", {31'b0, bus.bus_req}, 32'd1);
        #2;
        reset    = 1'b0;
        MemReadM = 1'b0;
        #1;
        chk("mid_req",   {31'b0, bus.bus_req}, 32'd0);
        chk("mid_addr",  bus.bus_addr,  32'd0);
        chk("mid_rdata", ReadDataM,     32'd0);
        chk("mid_fault", {31'b0, MemFault}, 32'd0);
        chk("mid_stall", {31'b0, StallM},   32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'hFFFF_0000;
        bus.bus_err   = 1'b1;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        bus.bus_err = 1'b0;
        chk("late_ack_req",   {31'b0, bus.bus_req}, 32'd0);
        chk("late_ack_rdata", ReadDataM, 32'd0);
        chk("late_ack_fault", {31'b0, MemFault}, 32'd0);
        chk("late_ack_stall", {31'b0, StallM},   32'd0);

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
